// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming 2-D pooling over POOL x POOL non-overlapping windows.
//
// Takes one raster-ordered pixel per valid_in cycle, with CH lanes side by side,
// and emits one pooled value per lane for each complete window. A run-time mode
// selects max pooling or floor-average pooling. The mode is latched on the first
// pixel of each frame.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   mode_avg   0 = max, 1 = average; sampled on pixel (0,0)
//   valid_in   pixel_in valid this cycle
//   pixel_in   CH lanes, lane k at [k*DATA_W +: DATA_W]
//   pool_out   pooled result per lane; holds between windows
//   valid_out  one-cycle pulse, one cycle after a window's bottom-right pixel
//   out_col    output column of pool_out
//   out_row    output row of pool_out
//   frame_done one-cycle pulse, one cycle after pixel (IMG_W-1, IMG_H-1)
module pool2d_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned POOL   = 2,   // 2 or 4
    parameter int unsigned CH     = 1,
    localparam int unsigned OUT_W = IMG_W / POOL,
    localparam int unsigned OUT_H = IMG_H / POOL,
    localparam int unsigned OC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int unsigned OR_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_avg,
    input  logic                 valid_in,
    input  logic [CH*DATA_W-1:0] pixel_in,
    output logic [CH*DATA_W-1:0] pool_out,
    output logic                 valid_out,
    output logic [OC_W-1:0]      out_col,
    output logic [OR_W-1:0]      out_row,
    output logic                 frame_done
);

    localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned LOG2P = $clog2(POOL);
    localparam int unsigned SH    = 2 * LOG2P;
    // Wide enough to hold the sum of POOL*POOL pixels in average mode.
    localparam int unsigned ACC_W = DATA_W + SH;
    localparam logic [LOG2P-1:0] PH_LAST = LOG2P'(POOL - 1);

    typedef logic [ACC_W-1:0] acc_t;

    function automatic acc_t combine(input logic avg, input acc_t a, input acc_t b);
        if (avg) begin
            return a + b;
        end
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]              col_q, col_d;
    logic [RW-1:0]              row_q, row_d;
    logic                       mode_q, mode_d;
    logic [CH-1:0][ACC_W-1:0]   hacc_q, hacc_d;
    logic [CH-1:0][DATA_W-1:0]  pool_q, pool_d;
    logic                       vout_q, vout_d;
    logic [OC_W-1:0]            ocol_q, ocol_d;
    logic [OR_W-1:0]            orow_q, orow_d;
    logic                       fdone_q, fdone_d;

    // One partial window result per output column; no reset needed because the
    // first row of every window overwrites its entry.
    logic [CH-1:0][ACC_W-1:0]   lbuf_q [OUT_W];
    logic [CH-1:0][ACC_W-1:0]   lbuf_wdata;
    logic                       lbuf_we;

    logic [LOG2P-1:0] hph, vph;
    logic [OC_W-1:0]  gidx;
    logic [OR_W-1:0]  vidx;
    logic             first_pix, last_pix, mode_eff, in_area, grp_end, win_end;
    acc_t             pix, grp, tot;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        mode_d     = mode_q;
        hacc_d     = hacc_q;
        pool_d     = pool_q;
        vout_d     = 1'b0;
        ocol_d     = ocol_q;
        orow_d     = orow_q;
        fdone_d    = 1'b0;
        lbuf_we    = 1'b0;
        lbuf_wdata = '0;
        pix        = '0;
        grp        = '0;
        tot        = '0;

        hph       = col_q[LOG2P-1:0];
        vph       = row_q[LOG2P-1:0];
        gidx      = OC_W'(col_q >> LOG2P);
        vidx      = OR_W'(row_q >> LOG2P);
        first_pix = (col_q == '0) && (row_q == '0);
        last_pix  = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));
        // The frame's first pixel must already use the mode being latched.
        mode_eff  = first_pix ? mode_avg : mode_q;
        in_area   = (32'(col_q) < OUT_W * POOL) && (32'(row_q) < OUT_H * POOL);
        grp_end   = (hph == PH_LAST);
        win_end   = grp_end && (vph == PH_LAST);

        if (valid_in) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (first_pix) begin
                mode_d = mode_avg;
            end
            fdone_d = last_pix;

            // Remainder columns/rows are consumed without touching any state.
            if (in_area) begin
                for (int k = 0; k < CH; k++) begin
                    pix       = acc_t'(pixel_in[k*DATA_W +: DATA_W]);
                    grp       = (hph == '0) ? pix : combine(mode_eff, hacc_q[k], pix);
                    hacc_d[k] = grp;
                    tot       = (vph == '0) ? grp : combine(mode_eff, lbuf_q[gidx][k], grp);
                    lbuf_wdata[k] = tot;
                    if (win_end) begin
                        pool_d[k] = mode_eff ? DATA_W'(tot >> SH) : DATA_W'(tot);
                    end
                end
                lbuf_we = grp_end && !win_end;
                if (win_end) begin
                    vout_d = 1'b1;
                    ocol_d = gidx;
                    orow_d = vidx;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            mode_q  <= 1'b0;
            hacc_q  <= '0;
            pool_q  <= '0;
            vout_q  <= 1'b0;
            ocol_q  <= '0;
            orow_q  <= '0;
            fdone_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            mode_q  <= mode_d;
            hacc_q  <= hacc_d;
            pool_q  <= pool_d;
            vout_q  <= vout_d;
            ocol_q  <= ocol_d;
            orow_q  <= orow_d;
            fdone_q <= fdone_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lbuf_we) begin
            lbuf_q[gidx] <= lbuf_wdata;
        end
    end

    assign pool_out   = pool_q;
    assign valid_out  = vout_q;
    assign out_col    = ocol_q;
    assign out_row    = orow_q;
    assign frame_done = fdone_q;

endmodule
